// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions: datapath width, register address width and the
// debug-controller state encoding.
package rv32i_pkg;

    localparam int XLEN           = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } rv32i_dbg_state_e;

endpackage

// File: rtl/rv32i_regfile_dbg_ctrl.sv
// Debug-access controller for the rv32i register file.
// Sequences one debug read or write at a time against core writeback. Core
// writeback always wins the shared write port; a saturating starvation counter
// raises core_stall so a blocked debug write eventually commits.
// Optional feature: define RV32I_DBG_FWD_EN to forward wb_data to a debug read
// that collides with a same-address core write, instead of waiting it out.
module rv32i_regfile_dbg_ctrl
    import rv32i_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      dbg_req_valid,
    output logic                      dbg_req_ready,
    input  logic                      dbg_req_write,
    input  logic [REG_ADDR_WIDTH-1:0] dbg_req_addr,
    input  logic [XLEN-1:0]           dbg_req_wdata,
    output logic                      dbg_rsp_valid,
    input  logic                      dbg_rsp_ready,
    output logic [XLEN-1:0]           dbg_rsp_rdata,
    input  logic                      wb_we,
    input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
    input  logic [XLEN-1:0]           wb_data,
    output logic                      core_stall,
    output logic [REG_ADDR_WIDTH-1:0] rf_dbg_addr,
    output logic [XLEN-1:0]           rf_dbg_wdata,
    output logic                      rf_dbg_we,
    input  logic [XLEN-1:0]           rf_dbg_rdata
);

`ifdef RV32I_DBG_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    localparam int            CW      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

    rv32i_dbg_state_e          state;
    logic                      wr_q;
    logic [REG_ADDR_WIDTH-1:0] addr_q;
    logic [XLEN-1:0]           wdata_q;
    logic [CW-1:0]             cnt;
    logic [CW-1:0]             cnt_inc;
    logic                      hazard;
    logic                      read_go;
    logic [XLEN-1:0]           rd_val;

    // Core write to the register a pending debug read targets (x0 never collides).
    assign hazard = wb_we && (wb_addr == addr_q) && (addr_q != '0);

    assign dbg_req_ready = (state == IDLE) && !rst;
    assign rf_dbg_addr   = addr_q;
    assign rf_dbg_wdata  = wdata_q;
    // Write port is ours only when the core is not writing back; never during reset.
    assign rf_dbg_we     = (state == WRITE) && wr_q && !wb_we && !rst;
    assign cnt_inc       = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

    // Read sample value: regfile data, forwarded wb_data on a hazard, x0 forced to zero.
    always_comb begin
        rd_val  = rf_dbg_rdata;
        read_go = !hazard;
        if (FWD_EN && hazard) begin
            rd_val  = wb_data;
            read_go = 1'b1;
        end
        if (addr_q == '0) begin
            rd_val = '0;
        end
    end

    // Controller FSM with latched request, response register and starvation stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wr_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            dbg_rsp_valid <= 1'b0;
            dbg_rsp_rdata <= '0;
            core_stall    <= 1'b0;
            cnt           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dbg_req_valid && dbg_req_ready) begin
                        wr_q    <= dbg_req_write;
                        addr_q  <= dbg_req_addr;
                        wdata_q <= dbg_req_wdata;
                        cnt     <= '0;
                        state   <= dbg_req_write ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (!wb_we) begin
                        cnt           <= '0;
                        core_stall    <= 1'b0;
                        dbg_rsp_rdata <= '0;
                        dbg_rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else begin
                        cnt        <= cnt_inc;
                        core_stall <= (cnt_inc >= CNT_MAX);
                    end
                end
                READ: begin
                    if (read_go) begin
                        dbg_rsp_rdata <= rd_val;
                        dbg_rsp_valid <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (dbg_rsp_ready) begin
                        dbg_rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_regfile_dbg_ctrl.sv
// Bench for rv32i_regfile_dbg_ctrl: a behavioral regfile, a response
// scoreboard checked by an independent monitor, and directed timing checks.
// Honours RV32I_DBG_FWD_EN for the read-hazard latency expectation.
module tb_rv32i_regfile_dbg_ctrl;

`ifdef RV32I_DBG_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        dbg_req_valid, dbg_req_ready, dbg_req_write;
    logic [4:0]  dbg_req_addr;
    logic [31:0] dbg_req_wdata;
    logic        dbg_rsp_valid, dbg_rsp_ready;
    logic [31:0] dbg_rsp_rdata;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        core_stall;
    logic [4:0]  rf_dbg_addr;
    logic [31:0] rf_dbg_wdata;
    logic        rf_dbg_we;
    logic [31:0] rf_dbg_rdata;

    logic        mdl_clr;
    logic [31:0] rf [32];
    logic [31:0] exp_q [$];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    rv32i_regfile_dbg_ctrl #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
        .dbg_req_write(dbg_req_write), .dbg_req_addr(dbg_req_addr),
        .dbg_req_wdata(dbg_req_wdata),
        .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready),
        .dbg_rsp_rdata(dbg_rsp_rdata),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .core_stall(core_stall),
        .rf_dbg_addr(rf_dbg_addr), .rf_dbg_wdata(rf_dbg_wdata),
        .rf_dbg_we(rf_dbg_we), .rf_dbg_rdata(rf_dbg_rdata)
    );

    // Behavioral register file: x0 hardwired, combinational read.
    always @(posedge clk) begin
        if (mdl_clr) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            if (wb_we && wb_addr != 0) rf[wb_addr] <= wb_data;
            if (rf_dbg_we && rf_dbg_addr != 0) rf[rf_dbg_addr] <= rf_dbg_wdata;
        end
    end
    assign rf_dbg_rdata = (rf_dbg_addr == 0) ? 32'h0 : rf[rf_dbg_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every response handshake pops one expected value.
    always @(negedge clk) begin
        if (!rst && dbg_rsp_valid && dbg_rsp_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got %h expected none", dbg_rsp_rdata);
            end else begin
                chk("rsp_rdata", dbg_rsp_rdata, exp_q.pop_front());
            end
        end
    end

    // Present a request; returns at #1 after the accepting edge (cycle T+1).
    task automatic issue(input logic wr, input logic [4:0] a, input logic [31:0] d,
                         input logic [31:0] exp);
        int n = 0;
        dbg_req_valid = 1'b1;
        dbg_req_write = wr;
        dbg_req_addr  = a;
        dbg_req_wdata = d;
        @(negedge clk);
        while (!dbg_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!dbg_req_ready) begin
            tests++;
            fails++;
            $display("FAIL req_timeout: got ready=0 expected ready=1");
        end else begin
            exp_q.push_back(exp);
        end
        @(posedge clk);
        #1;
        dbg_req_valid = 1'b0;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait until all responses drained and the controller is idle again.
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(exp_q.size() == 0 && dbg_req_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!(exp_q.size() == 0 && dbg_req_ready)) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: got pending=%0d expected 0", exp_q.size());
        end
        next_cyc();
    endtask

    initial begin
        rst = 1'b1; mdl_clr = 1'b1;
        dbg_req_valid = 0; dbg_req_write = 0; dbg_req_addr = 0; dbg_req_wdata = 0;
        dbg_rsp_ready = 1; wb_we = 0; wb_addr = 0; wb_data = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'b0, dbg_req_ready}, 0);
        chk("rst_rsp_valid", {31'b0, dbg_rsp_valid}, 0);
        chk("rst_rsp_rdata", dbg_rsp_rdata, 0);
        chk("rst_core_stall", {31'b0, core_stall}, 0);
        chk("rst_rf_we", {31'b0, rf_dbg_we}, 0);
        chk("rst_rf_addr", {27'b0, rf_dbg_addr}, 0);
        chk("rst_rf_wdata", rf_dbg_wdata, 0);
        next_cyc();
        rst = 0; mdl_clr = 0;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, dbg_req_ready}, 1);
        next_cyc();

        // Unblocked write x5, then read it back.
        issue(1'b1, 5'd5, 32'hCAFEBABE, 32'h0);
        @(negedge clk);
        chk("wr_we_T1", {31'b0, rf_dbg_we}, 1);
        chk("wr_addr_T1", {27'b0, rf_dbg_addr}, 5);
        chk("wr_data_T1", rf_dbg_wdata, 32'hCAFEBABE);
        chk("wr_vld_T1", {31'b0, dbg_rsp_valid}, 0);
        next_cyc();
        @(negedge clk);
        chk("wr_vld_T2", {31'b0, dbg_rsp_valid}, 1);
        chk("wr_we_T2", {31'b0, rf_dbg_we}, 0);
        wait_idle();
        issue(1'b0, 5'd5, 32'h0, 32'hCAFEBABE);
        @(negedge clk);
        chk("rd_vld_T1", {31'b0, dbg_rsp_valid}, 0);
        next_cyc();
        @(negedge clk);
        chk("rd_vld_T2", {31'b0, dbg_rsp_valid}, 1);
        wait_idle();

        // Starved write x7: core writes x3 for 6 cycles.
        wb_we = 1; wb_addr = 5'd3; wb_data = 32'h00000033;
        issue(1'b1, 5'd7, 32'h12345678, 32'h0);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk($sformatf("starve_stall_c%0d", i), {31'b0, core_stall}, (i >= 5) ? 1 : 0);
            chk($sformatf("starve_we_c%0d", i), {31'b0, rf_dbg_we}, 0);
            next_cyc();
        end
        wb_we = 0;
        @(negedge clk);
        chk("starve_commit_we", {31'b0, rf_dbg_we}, 1);
        chk("starve_commit_stall", {31'b0, core_stall}, 1);
        next_cyc();
        @(negedge clk);
        chk("starve_stall_fall", {31'b0, core_stall}, 0);
        chk("starve_rsp_vld", {31'b0, dbg_rsp_valid}, 1);
        wait_idle();
        issue(1'b0, 5'd7, 32'h0, 32'h12345678);
        wait_idle();
        issue(1'b0, 5'd3, 32'h0, 32'h00000033);
        wait_idle();

        // Read hazard on x9 (old 0x11111111, core writes 0x0000BEEF in T+1).
        wb_we = 1; wb_addr = 5'd9; wb_data = 32'h11111111;
        next_cyc();
        wb_we = 0;
        issue(1'b0, 5'd9, 32'h0, 32'h0000BEEF);
        wb_we = 1; wb_addr = 5'd9; wb_data = 32'h0000BEEF;
        next_cyc();
        wb_we = 0;
        @(negedge clk);
        chk("haz_vld_T2", {31'b0, dbg_rsp_valid}, FWD ? 1 : 0);
        if (!FWD) begin
            next_cyc();
            @(negedge clk);
            chk("haz_vld_T3", {31'b0, dbg_rsp_valid}, 1);
        end
        wait_idle();

        // x0: write has no effect; read returns 0 even with a core write to x0.
        issue(1'b1, 5'd0, 32'hFFFFFFFF, 32'h0);
        wait_idle();
        issue(1'b0, 5'd0, 32'h0, 32'h0);
        wb_we = 1; wb_addr = 5'd0; wb_data = 32'hDEADBEEF;
        next_cyc();
        wb_we = 0;
        @(negedge clk);
        chk("x0_rd_vld_T2", {31'b0, dbg_rsp_valid}, 1);
        wait_idle();

        // Response backpressure with a competing request held valid.
        dbg_rsp_ready = 0;
        issue(1'b0, 5'd5, 32'h0, 32'hCAFEBABE);
        next_cyc();
        dbg_req_valid = 1; dbg_req_write = 1; dbg_req_addr = 5'd5; dbg_req_wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_vld_c%0d", i), {31'b0, dbg_rsp_valid}, 1);
            chk($sformatf("bp_rdata_c%0d", i), dbg_rsp_rdata, 32'hCAFEBABE);
            chk($sformatf("bp_ready_c%0d", i), {31'b0, dbg_req_ready}, 0);
            next_cyc();
        end
        dbg_req_valid = 0;
        dbg_rsp_ready = 1;
        wait_idle();
        issue(1'b0, 5'd5, 32'h0, 32'hCAFEBABE);
        wait_idle();

        // Reset while blocked in WRITE: transaction dropped, nothing committed.
        wb_we = 1; wb_addr = 5'd4; wb_data = 32'h00000044;
        issue(1'b1, 5'd6, 32'hAAAA5555, 32'h0);
        repeat (5) next_cyc();
        rst = 1; wb_we = 0;
        @(negedge clk);
        chk("rst_mid_we", {31'b0, rf_dbg_we}, 0);
        void'(exp_q.pop_back());
        next_cyc();
        rst = 0;
        @(negedge clk);
        chk("rst_mid_ready", {31'b0, dbg_req_ready}, 1);
        chk("rst_mid_stall", {31'b0, core_stall}, 0);
        chk("rst_mid_vld", {31'b0, dbg_rsp_valid}, 0);
        repeat (3) next_cyc();
        @(negedge clk);
        chk("rst_mid_no_rsp", {31'b0, dbg_rsp_valid}, 0);
        next_cyc();
        issue(1'b0, 5'd6, 32'h0, 32'h0);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rv32i_regfile_dbg_ctrl.md
# rv32i_regfile_dbg_ctrl

Debug-access controller for the rv32i register file. It owns the register file's debug port and its write-port sharing: debug read and write requests arrive through a valid/ready request/response handshake, and the block sequences them against core writeback. Core writeback always has priority, and a starvation counter stalls the core so a pending debug write can commit. It sits between the debug module and `rv32i_regfile`, alongside the core's writeback stage.

## Interface
Parameters:
- `STARVE_LIMIT`, 4: consecutive blocked debug-write cycles before `core_stall` asserts; legal range ≥1.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `dbg_req_valid` in 1: debug request valid.
- `dbg_req_ready` out 1: request accepted when valid & ready.
- `dbg_req_write` in 1: 1 = write, 0 = read.
- `dbg_req_addr` in REG_ADDR_WIDTH: target register.
- `dbg_req_wdata` in XLEN: write data.
- `dbg_rsp_valid` out 1: response valid.
- `dbg_rsp_ready` in 1: response consumed when valid & ready.
- `dbg_rsp_rdata` out XLEN: read data; 0 for writes.
- `wb_we` in 1: core writeback enable.
- `wb_addr` in REG_ADDR_WIDTH: core writeback address.
- `wb_data` in XLEN: core writeback data.
- `core_stall` out 1: request that the core hold `wb_we` low.
- `rf_dbg_addr` out REG_ADDR_WIDTH: to the regfile `dbg_addr`.
- `rf_dbg_wdata` out XLEN: to the regfile `dbg_wdata`.
- `rf_dbg_we` out 1: to the regfile `dbg_we`.
- `rf_dbg_rdata` in XLEN: from the regfile `dbg_rdata` (combinational read).

## Operation
- States: IDLE, WRITE, READ, RESP.
- IDLE:
  - `dbg_req_ready`=1.
  - On handshake, latch write flag, address and data into internal registers.
  - Go to WRITE if the request is a write, otherwise READ.
- WRITE:
  - If `wb_we`=0: `rf_dbg_we`=1 for this cycle (commit), response data is 0, go to RESP.
  - If `wb_we`=1: blocked, `rf_dbg_we`=0. The starvation counter increments (saturating) and the state holds.
- READ:
  - `rf_dbg_rdata` is captured into the response register, then go to RESP.
  - Same-address hazard: `wb_we`=1 and `wb_addr`=latched address ≠0 in this cycle. Handling depends on `RV32I_DBG_FWD_EN` (see Configuration).
- RESP:
  - `dbg_rsp_valid`=1 and the response data is held stable.
  - On `dbg_rsp_ready`, go to IDLE.
- `rf_dbg_addr` and `rf_dbg_wdata` always drive the latched values; `rf_dbg_we` is high only in a WRITE commit cycle.
- Register x0:
  - A write to x0 completes normally with no architectural effect.
  - A read of x0 returns 0, including under forwarding.
- The starvation counter clears on entry to WRITE and on commit.

## Timing
- Reset values: state=IDLE, `dbg_req_ready`=0 during reset then 1, `dbg_rsp_valid`=0, `dbg_rsp_rdata`=0, `core_stall`=0, `rf_dbg_we`=0, latched address/data=0, counter=0.
- Request accepted at edge T:
  - Unblocked write: commits in cycle T+1; `dbg_rsp_valid` is high from T+2.
  - Read: samples in cycle T+1; `dbg_rsp_valid` is high from T+2.
- `core_stall` (registered):
  - Goes high in the cycle after the STARVE_LIMIT-th consecutive blocked WRITE cycle.
  - Goes low in the cycle after the commit.
  - If the core violates the stall contract, the core still wins and the request stays pending.
- Reset asserted mid-transaction: the transaction is dropped and no response is issued. Any `rf_dbg_we` pulse in the reset cycle is suppressed.
- No new request is accepted until the RESP handshake completes: one outstanding transaction at a time.

## Configuration
- With `RV32I_DBG_FWD_EN` defined: a READ hazard returns `wb_data` directly. Latency is unchanged.
- Without it: READ holds for each hazard cycle and samples in the first hazard-free cycle, after the write has landed. Latency is +1 per hazard cycle.

## Structure
- `rv32i_pkg` supplies XLEN and REG_ADDR_WIDTH.
- The `rv32i_dbg_state_e` enum (IDLE/WRITE/READ/RESP) is added to `rv32i_pkg`.
- Single flat module; the counter and FSM are too small to justify a sub-module.

## Test plan
- Debug write x5=0xCAFEBABE with `wb_we`=0 → `rf_dbg_we` pulses at T+1, response valid at T+2 with rdata 0; a subsequent read of x5 returns 0xCAFEBABE.
- `wb_we` held high for 6 cycles during debug write x7=0x12345678 with STARVE_LIMIT=4 → `core_stall` rises after the 4th blocked cycle. The write commits on the first cycle `wb_we`=0; `core_stall` falls the cycle after.
- Debug read x9 while `wb_we` writes x9=0x0000BEEF (old value 0x11111111) → FWD_EN returns 0x0000BEEF at T+2; non-FWD returns 0x0000BEEF at T+3.
- Debug write x0=0xFFFFFFFF, then read x0 → read response 0x00000000.
- `dbg_rsp_ready` held low for 5 cycles → `dbg_rsp_valid` and rdata stay stable, and `dbg_req_ready`=0 throughout.
- `rst` asserted while blocked in WRITE → no commit, no response, `core_stall`=0, and `dbg_req_ready`=1 the cycle after `rst` deasserts.
